grid_env_stepper: RTL
=====================

Name: grid_env_stepper

Overview:
Parametrised, clocked grid-world environment for the RL datapath. It generalises the 5x5 combinational move selector to a GRID_W x GRID_H grid, using 1-based state indices numbered row-major from the top-left. Per episode it holds the agent state, accepts one action per valid/ready handshake, and applies edge clipping on every border. For each step it returns the next state, a signed reward and an episode-done flag to the Q-update stage.

Parameters:
GRID_W, 5, grid columns (>=2)
GRID_H, 5, grid rows (>=2)
START_STATE, 1, episode start index (1..GRID_W*GRID_H)
GOAL_STATE, 25, terminal index (1..GRID_W*GRID_H, != START_STATE)
MAX_STEPS, 64, episode timeout in steps (1..2**CW-1)
CW, 8, step counter width
RW, 8, signed reward width
R_STEP, -1, reward for a normal move
R_BUMP, -5, reward for a clipped move or an illegal action code
R_GOAL, 100, reward for entering GOAL_STATE
derived SW = $clog2(GRID_W*GRID_H+1), state width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin or restart an episode
act_valid  in  1  action offered
act_ready  out  1  action accepted when act_valid && act_ready
action  in  4  0=right 1=up 2=left 3=down; other codes are illegal
state  out  SW  current agent state
step_valid  out  1  one-cycle pulse: the step result below is valid
reward  out  RW  signed reward of the last step
done  out  1  episode terminated (high in DONE)
timeout  out  1  termination was caused by MAX_STEPS
step_count  out  CW  steps taken this episode

Behaviour:
- Reset, asynchronous: FSM=IDLE, state=START_STATE, all other outputs 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: act_ready=0. start -> RUN.
- RUN: act_ready = !start.
- DONE: act_ready=0, done=1. start -> RUN.
- Entering RUN via start, from any state: state<=START_STATE, step_count<=0, done<=0, timeout<=0. No step_valid pulse.
- start has priority over act_valid in the same cycle; act_ready=0, so the action is not consumed.
- Step accepted at edge t; at t+1, state, reward, step_count and done are updated and step_valid=1 for exactly one cycle. Latency is 1, throughput 1 step per cycle.
- Move rule, with col = (s-1)%GRID_W and row = (s-1)/GRID_W:
  - right: +1 if col<GRID_W-1
  - left: -1 if col>0
  - up: -GRID_W if row>0
  - down: +GRID_W if row<GRID_H-1
  - otherwise the state is unchanged and the step is a bump.
- Illegal action code: state unchanged, reward R_BUMP, counts as a step.
- Reward priority: next==GOAL_STATE -> R_GOAL, else bump -> R_BUMP, else R_STEP.
- step_count <= step_count+1 on every accepted step.
- Termination:
  - next==GOAL_STATE -> DONE, timeout=0.
  - else step_count+1==MAX_STEPS -> DONE, timeout=1.
  - Goal reached on the last allowed step counts as goal, timeout=0.
- reward, timeout and step_count hold their values until the next step or start.
- Reset asserted mid-episode aborts the episode immediately with no handshake.
- Arithmetic: reward parameters are sign-extended or truncated to RW; col/row arithmetic is done at SW+1 bits.

Optional Feature:
GRID_WALL_EN.
- Defined: adds parameter WALL_MASK[GRID_W*GRID_H-1:0]; bit k=1 marks state k+1 as a wall. A move whose target is a wall is treated as a bump: state unchanged, reward R_BUMP. START_STATE and GOAL_STATE must not be walls; an elaboration-time check enforces this.
- Undefined: no walls; only edge clipping applies. Ports are identical in both builds.

Decomposition:
- Package grid_env_pkg: action enum (ACT_RIGHT/UP/LEFT/DOWN), FSM state enum, and helper function state_width(w,h).
- One sub-module, grid_move_calc: combinational (state, action) -> (next_state, bump), covering clipping and walls. It is reusable by the Q-table address generator.

Test Plan:
- Reset, then start, then right x4 from state 1 -> states 2,3,4,5 with reward -1 each; a 5th right -> state 5, reward -5, step_count=5.
- From 1: down x4, then right x4 -> the final step enters state 25 with reward 100, done=1, timeout=0, step_count=8; act_ready=0 afterwards.
- MAX_STEPS=3, actions up,left,up from 1 -> three bumps (reward -5 each); done=1, timeout=1 after the 3rd step.
- Action code 7 from state 13 -> state 13, reward -5, step_count increments.
- start and act_valid asserted together in RUN at state 12 -> no handshake, state=1, step_count=0, no step_valid pulse.
- GRID_W=7, GRID_H=3, with GRID_WALL_EN and WALL_MASK bit 1 set: right from state 1 -> state 1, reward -5. Second part: reset pulsed mid-episode -> IDLE, state=1 immediately.

Source files
------------

// File: rtl/grid_env_pkg.sv
// Shared types and helpers for the grid-world environment stepper and its move calculator.
package grid_env_pkg;

    typedef enum logic [1:0] {
        ACT_RIGHT = 2'd0,
        ACT_UP    = 2'd1,
        ACT_LEFT  = 2'd2,
        ACT_DOWN  = 2'd3
    } action_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Width able to hold 1-based state indices 1..w*h.
    function automatic int state_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/grid_move_calc.sv
// Combinational (state, action) -> (next_state, bump) with border clipping.
// Optional walls are enabled by defining GRID_WALL_EN.
module grid_move_calc
    import grid_env_pkg::*;
#(
    parameter int GRID_W = 5,
    parameter int GRID_H = 5
`ifdef GRID_WALL_EN
    ,
    parameter logic [GRID_W*GRID_H-1:0] WALL_MASK = '0
`endif
) (
    input  logic [state_width(GRID_W, GRID_H)-1:0] state_i,
    input  logic [3:0]                             action_i,
    output logic [state_width(GRID_W, GRID_H)-1:0] next_state_o,
    output logic                                   bump_o
);

    localparam int SW = state_width(GRID_W, GRID_H);
    localparam logic [SW:0] ONE_X = (SW+1)'(1);
    localparam logic [SW:0] W_X   = (SW+1)'(GRID_W);
    localparam logic [SW:0] H_X   = (SW+1)'(GRID_H);

    logic [SW:0] s_ext;
    logic [SW:0] idx;
    logic [SW:0] col;
    logic [SW:0] row;
    logic [SW:0] target;
    logic        move_ok;

    // One extra bit keeps the "state - 1" and "state + GRID_W" sums from wrapping.
    assign s_ext = {1'b0, state_i};
    assign idx   = s_ext - ONE_X;
    assign col   = idx % W_X;
    assign row   = idx / W_X;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        target       = s_ext;
        move_ok      = 1'b0;
        next_state_o = state_i;
        bump_o       = 1'b1;

        if (action_i[3:2] == 2'b00) begin
            unique case (action_e'(action_i[1:0]))
                ACT_RIGHT: if (col < W_X - ONE_X) begin target = s_ext + ONE_X; move_ok = 1'b1; end
                ACT_UP:    if (row != '0)         begin target = s_ext - W_X;   move_ok = 1'b1; end
                ACT_LEFT:  if (col != '0)         begin target = s_ext - ONE_X; move_ok = 1'b1; end
                ACT_DOWN:  if (row < H_X - ONE_X) begin target = s_ext + W_X;   move_ok = 1'b1; end
            endcase
        end

`ifdef GRID_WALL_EN
        for (int k = 0; k < GRID_W * GRID_H; k++) begin
            if (WALL_MASK[k] && target == (SW+1)'(k + 1)) move_ok = 1'b0;
        end
`endif

        if (move_ok) begin
            next_state_o = target[SW-1:0];
            bump_o       = 1'b0;
        end
    end

endmodule

// File: rtl/grid_env_stepper.sv
// Clocked grid-world environment: one action per handshake, returns next state, reward and done.
// Define GRID_WALL_EN to add the WALL_MASK parameter and wall collisions.
module grid_env_stepper
    import grid_env_pkg::*;
#(
    parameter int GRID_W      = 5,
    parameter int GRID_H      = 5,
    parameter int START_STATE = 1,
    parameter int GOAL_STATE  = 25,
    parameter int MAX_STEPS   = 64,
    parameter int CW          = 8,
    parameter int RW          = 8,
    parameter int R_STEP      = -1,
    parameter int R_BUMP      = -5,
    parameter int R_GOAL      = 100
`ifdef GRID_WALL_EN
    ,
    parameter logic [GRID_W*GRID_H-1:0] WALL_MASK = '0
`endif
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   act_valid,
    output logic                                   act_ready,
    input  logic [3:0]                             action,
    output logic [state_width(GRID_W, GRID_H)-1:0] state,
    output logic                                   step_valid,
    output logic [RW-1:0]                          reward,
    output logic                                   done,
    output logic                                   timeout,
    output logic [CW-1:0]                          step_count
);

    localparam int SW = state_width(GRID_W, GRID_H);
    localparam logic [SW-1:0] START_V  = SW'(START_STATE);
    localparam logic [SW-1:0] GOAL_V   = SW'(GOAL_STATE);
    localparam logic [CW-1:0] MAX_V    = CW'(MAX_STEPS);
    localparam logic [RW-1:0] R_STEP_V = RW'(R_STEP);
    localparam logic [RW-1:0] R_BUMP_V = RW'(R_BUMP);
    localparam logic [RW-1:0] R_GOAL_V = RW'(R_GOAL);

`ifdef GRID_WALL_EN
    if (WALL_MASK[START_STATE-1] || WALL_MASK[GOAL_STATE-1]) begin : g_wall_check
        $error("grid_env_stepper: START_STATE and GOAL_STATE must not be walls");
    end
`endif

    fsm_e          fsm_q, fsm_d;
    logic [SW-1:0] state_q, state_d;
    logic [RW-1:0] reward_q, reward_d;
    logic [CW-1:0] step_count_q, step_count_d;
    logic          timeout_q, timeout_d;
    logic          step_valid_q, step_valid_d;

    logic [SW-1:0] move_next;
    logic          move_bump;
    logic [CW-1:0] count_inc;
    logic          step_acc;
    logic          hit_goal;

    grid_move_calc #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H)
`ifdef GRID_WALL_EN
        ,
        .WALL_MASK(WALL_MASK)
`endif
    ) u_move (
        .state_i     (state_q),
        .action_i    (action),
        .next_state_o(move_next),
        .bump_o      (move_bump)
    );

    // start wins over a same-cycle action: the action is simply not taken.
    assign act_ready = (fsm_q == ST_RUN) && !start;
    assign step_acc  = act_ready && act_valid;
    assign count_inc = step_count_q + CW'(1);
    assign hit_goal  = (move_next == GOAL_V);

    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        reward_d     = reward_q;
        step_count_d = step_count_q;
        timeout_d    = timeout_q;
        step_valid_d = 1'b0;

        if (start) begin
            fsm_d        = ST_RUN;
            state_d      = START_V;
            reward_d     = '0;
            step_count_d = '0;
            timeout_d    = 1'b0;
        end else if (step_acc) begin
            state_d      = move_next;
            step_count_d = count_inc;
            step_valid_d = 1'b1;
            if (hit_goal) begin
                reward_d  = R_GOAL_V;
                fsm_d     = ST_DONE;
                timeout_d = 1'b0;
            end else begin
                reward_d = move_bump ? R_BUMP_V : R_STEP_V;
                if (count_inc == MAX_V) begin
                    fsm_d     = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= ST_IDLE;
            state_q      <= START_V;
            reward_q     <= '0;
            step_count_q <= '0;
            timeout_q    <= 1'b0;
            step_valid_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            reward_q     <= reward_d;
            step_count_q <= step_count_d;
            timeout_q    <= timeout_d;
            step_valid_q <= step_valid_d;
        end
    end

    assign state      = state_q;
    assign reward     = reward_q;
    assign step_count = step_count_q;
    assign timeout    = timeout_q;
    assign step_valid = step_valid_q;
    assign done       = (fsm_q == ST_DONE);

endmodule
